// File: rtl/uart_dac_cmd_rx_pkg.sv
// Shared definitions for the DAC command receiver: the frame header byte,
// the receiver state encoding and the frame checksum rule.
package uart_dac_cmd_rx_pkg;

  // The readback transmitter uses the same start byte.
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D0   = 3'd1,
    ST_D1   = 3'd2,
    ST_D2   = 3'd3,
    ST_CHK  = 3'd4,
    ST_HOLD = 3'd5
  } rx_state_e;

  function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle timer: counts clocks while run is high, clears on clr and
// flags expiry once TIMEOUT_CYC-1 is reached. Saturates instead of wrapping.
module uart_frame_timer #(
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (run && (count_q != LAST)) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && (count_q == LAST);

endmodule

// File: rtl/uart_dac_cmd_rx.sv
// Assembles framed 24-bit DAC command words (header, 3 data bytes MSB-first,
// XOR checksum) from UART byte strobes and hands them out on valid/ready.
module uart_dac_cmd_rx
  import uart_dac_cmd_rx_pkg::*;
#(
  parameter int          CLK_FREQ    = 50_000_000,
  parameter int          TIMEOUT_CYC = CLK_FREQ / 500,
  parameter logic [7:0]  HEADER      = HEADER_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic [23:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        err_timeout,
  output logic        err_checksum,
  output logic        err_overrun
);

  rx_state_e   state_q, state_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [23:0] cmd_data_q, cmd_data_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_checksum_q, err_checksum_d;
  logic        err_overrun_q, err_overrun_d;
  logic        timer_run, timer_clr, timer_expired;

  // Any strobe restarts the idle window, including the header that enters D0.
  assign timer_run = (state_q == ST_D0) || (state_q == ST_D1) ||
                     (state_q == ST_D2) || (state_q == ST_CHK);
  assign timer_clr = rx_done || !timer_run;

  uart_frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (timer_run),
    .clr    (timer_clr),
    .expired(timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    b0_d           = b0_q;
    b1_d           = b1_q;
    b2_d           = b2_q;
    cmd_data_d     = cmd_data_q;
    err_timeout_d  = 1'b0;
    err_checksum_d = 1'b0;
    err_overrun_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_done && (rx_data == HEADER)) state_d = ST_D0;
      end
      ST_D0: begin
        if (rx_done) begin
          b0_d    = rx_data;
          state_d = ST_D1;
        end else if (timer_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_D1: begin
        if (rx_done) begin
          b1_d    = rx_data;
          state_d = ST_D2;
        end else if (timer_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_D2: begin
        if (rx_done) begin
          b2_d    = rx_data;
          state_d = ST_CHK;
        end else if (timer_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (rx_done) begin
          if (rx_data == frame_checksum(b0_q, b1_q, b2_q)) begin
            cmd_data_d = {b0_q, b1_q, b2_q};
            state_d    = ST_HOLD;
          end else begin
            err_checksum_d = 1'b1;
            state_d        = ST_IDLE;
          end
        end else if (timer_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // A byte arriving with the accepting handshake is judged as in IDLE.
        if (cmd_ready) begin
          state_d = (rx_done && (rx_data == HEADER)) ? ST_D0 : ST_IDLE;
        end else if (rx_done) begin
          err_overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      b0_q           <= '0;
      b1_q           <= '0;
      b2_q           <= '0;
      cmd_data_q     <= '0;
      err_timeout_q  <= 1'b0;
      err_checksum_q <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      b0_q           <= b0_d;
      b1_q           <= b1_d;
      b2_q           <= b2_d;
      cmd_data_q     <= cmd_data_d;
      err_timeout_q  <= err_timeout_d;
      err_checksum_q <= err_checksum_d;
      err_overrun_q  <= err_overrun_d;
    end
  end

  assign cmd_data     = cmd_data_q;
  assign cmd_valid    = (state_q == ST_HOLD);
  assign err_timeout  = err_timeout_q;
  assign err_checksum = err_checksum_q;
  assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_uart_dac_cmd_rx.sv
// Scoreboard bench for uart_dac_cmd_rx: a byte-stream frame parser predicts
// commands and error pulses, a separate monitor compares what the DUT emits.
module tb_uart_dac_cmd_rx;

  localparam int TO = 40;
  localparam int KIND_TO = 1;
  localparam int KIND_CK = 2;
  localparam int KIND_OV = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cmd_ready = 1'b1;
  logic [23:0] cmd_data;
  logic        cmd_valid;
  logic        err_timeout, err_checksum, err_overrun;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_dac_cmd_rx #(
    .CLK_FREQ   (50_000_000),
    .TIMEOUT_CYC(TO),
    .HEADER     (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .err_timeout (err_timeout),
    .err_checksum(err_checksum),
    .err_overrun (err_overrun)
  );

  typedef struct { logic [23:0] data; int cyc; } cmd_exp_t;
  typedef struct { int kind; int cyc; } err_exp_t;

  cmd_exp_t cmd_q[$];
  err_exp_t err_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: parsing position in the byte stream.
  bit         m_in_frame = 1'b0;
  bit         m_hold = 1'b0;
  logic [7:0] m_buf[$];
  int         last_cyc = -100000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // A frame still open more than TO cycles after its last byte is abandoned.
  always @(negedge clk) begin
    if (rst_n && m_in_frame && (cyc - last_cyc) > TO) begin
      err_q.push_back('{KIND_TO, last_cyc + TO + 1});
      m_in_frame = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    while ((cyc - last_cyc) < gap) begin
      rx_done = 1'b0;
      @(negedge clk);
    end
    if (m_in_frame && (cyc - last_cyc) > TO) begin
      err_q.push_back('{KIND_TO, last_cyc + TO + 1});
      m_in_frame = 1'b0;
    end
    if (m_hold) begin
      err_q.push_back('{KIND_OV, cyc + 1});
    end else if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1'b1;
        m_buf.delete();
      end
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == 4) begin
        m_in_frame = 1'b0;
        if (m_buf[3] == (m_buf[0] ^ m_buf[1] ^ m_buf[2])) begin
          cmd_q.push_back('{{m_buf[0], m_buf[1], m_buf[2]}, cyc + 1});
          m_hold = !cmd_ready;
        end else begin
          err_q.push_back('{KIND_CK, cyc + 1});
        end
      end
    end
    $display("byte %02h sent at cycle %0d (gap %0d)", b, cyc, cyc - last_cyc);
    rx_done  = 1'b1;
    rx_data  = b;
    last_cyc = cyc;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] ck, input int gap);
    send_byte(8'hA5, gap);
    send_byte(d0, gap);
    send_byte(d1, gap);
    send_byte(d2, gap);
    send_byte(ck, gap);
  endtask

  task automatic set_ready(input logic v);
    repeat (2) @(negedge clk);
    cmd_ready = v;
    if (v) m_hold = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_cmd_data", {8'd0, cmd_data}, 32'd0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    chk("rst_err_checksum", {31'd0, err_checksum}, 32'd0);
    chk("rst_err_overrun", {31'd0, err_overrun}, 32'd0);
    m_in_frame = 1'b0;
    m_hold     = 1'b0;
    cmd_q.delete();
    err_q.delete();
    idle(3);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every error pulse and every accepted command.
  initial begin
    bit          vprev = 1'b0;
    int          rise_cyc = 0;
    logic [23:0] held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        vprev = 1'b0;
        continue;
      end
      if ((32'(err_timeout) + 32'(err_checksum) + 32'(err_overrun)) > 1)
        chk("err_exclusive", {29'd0, err_timeout, err_checksum, err_overrun}, 32'd0);
      if (err_timeout || err_checksum || err_overrun) begin
        int kind;
        kind = err_timeout ? KIND_TO : (err_checksum ? KIND_CK : KIND_OV);
        if (err_q.size() == 0) begin
          chk("unexpected_err_kind", 32'(kind), 32'd0);
        end else begin
          err_exp_t e;
          e = err_q.pop_front();
          chk("err_kind", 32'(kind), 32'(e.kind));
          chk("err_cycle", 32'(cyc), 32'(e.cyc));
          $display("err kind %0d at cycle %0d", kind, cyc);
        end
      end
      if (cmd_valid && !vprev) begin
        rise_cyc = cyc;
        held     = cmd_data;
      end else if (cmd_valid) begin
        chk("cmd_data_stable", {8'd0, cmd_data}, {8'd0, held});
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", {8'd0, cmd_data}, 32'd0);
        end else begin
          cmd_exp_t c;
          c = cmd_q.pop_front();
          chk("cmd_data", {8'd0, cmd_data}, {8'd0, c.data});
          chk("cmd_rise_cycle", 32'(rise_cyc), 32'(c.cyc));
          $display("cmd %06h accepted at cycle %0d", cmd_data, cyc);
        end
      end
      vprev = cmd_valid;
    end
  end

  initial begin
    #1;
    chk("init_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("init_cmd_data", {8'd0, cmd_data}, 32'd0);
    chk("init_err_any", {29'd0, err_timeout, err_checksum, err_overrun}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Good frame, then checksum failure.
    send_frame(8'h12, 8'h34, 8'h56, 8'h70, 10);
    send_frame(8'h12, 8'h34, 8'h56, 8'h71, 10);
    idle(5);
    chk("ck_no_valid", {31'd0, cmd_valid}, 32'd0);

    // Timeout after partial frame, then a clean frame.
    send_byte(8'hA5, 10);
    send_byte(8'h12, 10);
    idle(TO + 5);
    send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 10);

    // Gap exactly at the limit survives; one more cycle abandons the frame.
    send_byte(8'hA5, 5);
    send_byte(8'h01, TO);
    send_byte(8'h02, TO);
    send_byte(8'h03, TO);
    send_byte(8'h00, TO);
    send_byte(8'hA5, 5);
    send_byte(8'h01, TO + 1);

    // Held command with overrun, then a single accept.
    set_ready(1'b0);
    send_frame(8'h12, 8'h34, 8'h56, 8'h70, 10);
    send_byte(8'h55, 6);
    idle(20);
    chk("hold_valid", {31'd0, cmd_valid}, 32'd1);
    chk("hold_data", {8'd0, cmd_data}, 32'h123456);
    set_ready(1'b1);
    idle(3);
    chk("after_accept_valid", {31'd0, cmd_valid}, 32'd0);

    // Header on the accepting cycle starts the next frame directly.
    send_frame(8'h0F, 8'hF0, 8'h3C, 8'hC3, 4);
    send_byte(8'hA5, 1);
    send_byte(8'h11, 3);
    send_byte(8'h22, 3);
    send_byte(8'h44, 3);
    send_byte(8'h77, 3);

    // Junk ahead of the header is ignored.
    send_byte(8'h00, 7);
    send_byte(8'hFF, 7);
    send_byte(8'h12, 7);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00, 7);

    // Reset mid-frame, then a full frame.
    send_byte(8'hA5, 5);
    send_byte(8'h12, 5);
    send_byte(8'h34, 5);
    do_reset();
    idle(2);
    send_frame(8'h12, 8'h34, 8'h56, 8'h70, 10);

    // Randomised frames with junk, bad checksums and long gaps.
    for (int f = 0; f < 150; f++) begin
      int nj;
      logic [7:0] d0, d1, d2, ck, j;
      nj = $urandom_range(0, 2);
      for (int k = 0; k < nj; k++) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j, $urandom_range(1, 12));
      end
      d0 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      d2 = 8'($urandom_range(0, 255));
      ck = d0 ^ d1 ^ d2;
      if ($urandom_range(0, 4) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      send_byte(8'hA5, $urandom_range(1, 12));
      send_byte(d0, ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 12));
      send_byte(d1, $urandom_range(1, 12));
      send_byte(d2, ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 12));
      send_byte(ck, $urandom_range(1, 12));
    end

    idle(TO + 10);
    chk("cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
    chk("err_queue_empty", 32'(err_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
